wb_arb2: RTL and testbench
==========================

Name: wb_arb2

Overview:
Two-master to one-slave Wishbone B3 arbiter that shares a single slave port between two requesters. Typical use is the LM32 instruction and data buses sharing one block RAM or one peripheral port in front of the interconnect.
- Arbitration is round-robin or fixed-priority.
- A granted master keeps the bus for its whole CYC (bursts and locked sequences are not broken).
- A watchdog terminates stuck slave transfers with ERR.

Parameters:
prio_mode, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with m0 winning.
timeout_cycles, 255, number of unacknowledged strobe cycles before the watchdog aborts the transfer; range 1..65535; 0 disables the watchdog.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
m0_adr_i  in  32  master0 address
m0_dat_i  in  32  master0 write data
m0_dat_o  out  32  master0 read data
m0_sel_i  in  4  master0 byte select
m0_we_i  in  1  master0 write enable
m0_cyc_i  in  1  master0 cycle
m0_stb_i  in  1  master0 strobe
m0_ack_o  out  1  master0 acknowledge
m0_err_o  out  1  master0 error
m0_rty_o  out  1  master0 retry
m1_*  (same set as m0_*)  master1 port
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_dat_i  in  32  slave read data
s_sel_o  out  4  slave byte select
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_ack_i  in  1  slave acknowledge
s_err_i  in  1  slave error
s_rty_i  in  1  slave retry
grant_o  out  2  one-hot current owner, for status/debug

Behaviour:
- **Clock and reset:** one clock, clk_i. rst_i is asynchronous and active-high.
- **Reset values:**
  - state = IDLE; grant_o = 2'b00.
  - last-served register = m1, so m0 wins the first tie.
  - Watchdog counter = 0.
  - All s_* outputs = 0; all m*_ack/err/rty_o = 0.
- **States:** IDLE, GNT0, GNT1. The state register is the only arbitration state; the slave-side mux is combinational from it.
- **IDLE:**
  - Only m0_cyc_i set -> GNT0. Only m1_cyc_i set -> GNT1.
  - Both set, prio_mode=0 -> grant the master that was not last served.
  - Both set, prio_mode=1 -> GNT0.
- **GNTx:** held while mx_cyc_i=1. When mx_cyc_i falls:
  - Other master's cyc set -> GNTother directly, with no IDLE bubble; last-served updates to x.
  - Otherwise -> IDLE.
- **Latency:** a request seen in IDLE at edge N drives s_cyc_o/s_stb_o from cycle N+1. The arbiter adds 0 cycles to the slave's ACK path (ACK is combinational back to the master).
- **Mux in GNTx:**
  - s_adr/dat/sel/we/cyc/stb_o = mx_*_i.
  - mx_ack/err/rty_o = s_*_i.
  - Non-granted master sees ack/err/rty = 0.
  - Both m*_dat_o = s_dat_i.
- **Mux in IDLE:** all s_* outputs are 0.
- **Watchdog** (timeout_cycles != 0):
  - Counts every cycle with s_cyc_o & s_stb_o & ~(s_ack_i|s_err_i|s_rty_i).
  - Clears on any termination, on a grant change, or when stb drops.
  - When count == timeout_cycles-1 and still no termination: assert mx_err_o for exactly 1 cycle, force s_cyc_o/s_stb_o to 0 in that cycle, and clear the counter. The state stays GNTx until the master drops cyc.
  - If the slave ACKs in the same cycle the timeout fires, the ACK wins and no ERR is generated.
- **Counter width:** 16 bits, saturating and never wrapping.
- **Reset mid-transfer:** all outputs go to reset values immediately. An in-flight slave ACK after reset is ignored.

Decomposition:
- Include file wb_arb_defs.v holds the state encodings (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the prio_mode constants.
- One sub-module, wb_arb_watchdog: 16-bit counter with inputs active, term, clear and limit; single-cycle output fire.
- The arbiter FSM and the mux stay in wb_arb2.

Test Plan:
1. **Single master:** m0 reads 0x40000010 and the slave ACKs after 2 wait states -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o matches s_ack_i; m0_dat_o = 0xDEADBEEF; m1_ack_o stays 0.
2. **Round-robin tie** (prio_mode=0): both assert cyc in the same cycle, three times in a row -> grants are m0, m1, m0. With prio_mode=1 -> m0, m0, m0.
3. **Burst hold:** m1 holds cyc over 4 strobes while m0 requests -> grant_o stays 2'b10 for all 4 ACKs. When m1_cyc_i drops, grant_o = 2'b01 on the next edge with no IDLE cycle.
4. **Watchdog:** timeout_cycles=8, slave never ACKs -> m0_err_o is high for exactly 1 cycle, 8 cycles after stb; s_stb_o is low in that cycle. With the ACK arriving on cycle 8 instead -> ack only, no err.
5. **Async reset mid-burst:** assert rst_i between edges during a GNT1 transfer -> grant_o = 0 and s_cyc_o = 0 immediately, without waiting for a clock edge. After release, an m0 request is granted first.
6. **Error/retry pass-through:** the slave returns s_err_i, then s_rty_i, to m1 -> m1_err_o, then m1_rty_o, each for 1 cycle; m0 outputs remain 0.

Source files
------------

// File: rtl/wb_arb2_pkg.sv
// wb_arb2_pkg
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encodings, arbitration-mode constants, watchdog counter width and a
// helper that turns the FSM state into the one-hot grant vector.
package wb_arb2_pkg;

  // Arbitration state; the state register is the only arbitration state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // prio_mode values
  localparam int PRIO_RR    = 0;  // round-robin between m0 and m1
  localparam int PRIO_FIXED = 1;  // fixed priority, m0 wins ties

  // Watchdog counter width
  localparam int WD_WIDTH = 16;

  // One-hot owner vector for status/debug: bit0 = m0, bit1 = m1.
  function automatic logic [1:0] grant_of(input arb_state_t st);
    case (st)
      GNT0:    return 2'b01;
      GNT1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog
// Counts strobe cycles the slave has left unterminated and raises a
// single-cycle fire pulse when the count reaches limit-1 with still no
// termination. A limit of zero disables the watchdog.
//
// Ports:
//   clk    in   1         system clock
//   rst    in   1         asynchronous active-high reset
//   active in   1         a strobe is being presented to the slave
//   term   in   1         slave terminated the cycle (ack | err | rty)
//   clear  in   1         ownership is changing; restart the count
//   limit  in   WD_WIDTH  timeout in cycles, 0 = disabled
//   fire   out  1         abort the current transfer this cycle
module wb_arb_watchdog
  import wb_arb2_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                active,
  input  logic                term,
  input  logic                clear,
  input  logic [WD_WIDTH-1:0] limit,
  output logic                fire
);

  logic [WD_WIDTH-1:0] count;

  // A termination in the firing cycle suppresses the fire, so a late ACK
  // always wins over the timeout.
  assign fire = (limit != {WD_WIDTH{1'b0}}) && active && !term && !clear &&
                (count == (limit - {{(WD_WIDTH-1){1'b0}}, 1'b1}));

  // Wait-cycle counter: restarts on any termination, strobe drop, owner
  // change or abort, and saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {WD_WIDTH{1'b0}};
    end else if (clear || term || !active || fire) begin
      count <= {WD_WIDTH{1'b0}};
    end else if (count != {WD_WIDTH{1'b1}}) begin
      count <= count + {{(WD_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// wb_arb2
// Two-master to one-slave Wishbone B3 arbiter. A granted master keeps the
// slave for its whole CYC; ownership passes directly to a waiting master
// when the owner drops CYC. Ties are resolved round-robin (prio_mode=0) or
// in favour of m0 (prio_mode=1). A watchdog aborts stuck strobes with ERR.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   m0_*/m1_* adr,dat,sel,we,cyc,stb master request inputs
//   m0_*/m1_* dat_o,ack,err,rty      master response outputs
//   s_* adr,dat,sel,we,cyc,stb       slave request outputs
//   s_dat_i, s_ack/err/rty_i         slave response inputs
//   grant_o                          one-hot current owner (status/debug)
module wb_arb2
  import wb_arb2_pkg::*;
#(
  parameter int prio_mode      = 0,
  parameter int timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  grant_o
);

  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(timeout_cycles);

  arb_state_t state;
  logic       last_served;  // 0 = m0, 1 = m1 was served most recently
  logic       own_cyc;
  logic       own_stb;
  logic       term;
  logic       owner_leaving;
  logic       fire;

  assign term          = s_ack_i | s_err_i | s_rty_i;
  assign owner_leaving = (state != IDLE) && !own_cyc;

  // Owner's cyc/stb, used by the watchdog and the handover decision.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (state)
      GNT0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
      end
      GNT1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
      end
      default: begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
      end
    endcase
  end

  wb_arb_watchdog u_watchdog (
    .clk    (clk_i),
    .rst    (rst_i),
    .active (own_cyc & own_stb),
    .term   (term),
    .clear  (owner_leaving),
    .limit  (WD_LIMIT),
    .fire   (fire)
  );

  // Arbitration FSM. Reset leaves last_served = m1 so m0 wins the first
  // round-robin tie. Handover goes straight to the other master with no
  // IDLE bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if ((prio_mode == PRIO_FIXED) || last_served) begin
              state <= GNT0;
            end else begin
              state <= GNT1;
            end
          end else if (m0_cyc_i) begin
            state <= GNT0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
          end else begin
            state <= IDLE;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            last_served <= 1'b0;
            state       <= m1_cyc_i ? GNT1 : IDLE;
          end else begin
            state <= GNT0;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            last_served <= 1'b1;
            state       <= m0_cyc_i ? GNT0 : IDLE;
          end else begin
            state <= GNT1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data is broadcast; only the owner ever sees a termination.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = grant_of(state);

  // Slave-side mux and response routing. A watchdog fire masks cyc/stb
  // toward the slave and turns into ERR toward the owner for that cycle.
  always_comb begin
    s_adr_o  = 32'h0000_0000;
    s_dat_o  = 32'h0000_0000;
    s_sel_o  = 4'h0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i & ~fire;
        s_stb_o  = m0_stb_i & ~fire;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | fire;
        m0_rty_o = s_rty_i;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i & ~fire;
        s_stb_o  = m1_stb_i & ~fire;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | fire;
        m1_rty_o = s_rty_i;
      end
      default: begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2
// Two arbiters share one stimulus stream: instance 0 is round-robin,
// instance 1 is fixed priority, both with an 8-cycle watchdog. A
// behavioural model (owner as an integer, wait count as a plain integer)
// predicts every output each cycle; directed sequences add literal checks.
module tb_wb_arb2;

  localparam int TMO = 8;

  logic clk;
  logic rst;

  logic [31:0] m_adr [2];
  logic [31:0] m_wdat[2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic [31:0] s_rdat;
  logic        s_ack, s_err, s_rty;

  logic [31:0] o_mdat[2][2];
  logic        o_ack [2][2];
  logic        o_err [2][2];
  logic        o_rty [2][2];
  logic [31:0] o_sadr[2];
  logic [31:0] o_sdat[2];
  logic [3:0]  o_ssel[2];
  logic        o_swe [2];
  logic        o_scyc[2];
  logic        o_sstb[2];
  logic [1:0]  o_grant[2];

  // model state per instance: owner -1 = nobody
  int owner[2];
  int last [2];
  int wcnt [2];

  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arb2 #(.prio_mode(g), .timeout_cycles(TMO)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(o_mdat[g][0]),
      .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
      .m0_ack_o(o_ack[g][0]), .m0_err_o(o_err[g][0]), .m0_rty_o(o_rty[g][0]),
      .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(o_mdat[g][1]),
      .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
      .m1_ack_o(o_ack[g][1]), .m1_err_o(o_err[g][1]), .m1_rty_o(o_rty[g][1]),
      .s_adr_o(o_sadr[g]), .s_dat_o(o_sdat[g]), .s_dat_i(s_rdat), .s_sel_o(o_ssel[g]),
      .s_we_o(o_swe[g]), .s_cyc_o(o_scyc[g]), .s_stb_o(o_sstb[g]),
      .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
      .grant_o(o_grant[g])
    );
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %08h expected %08h at %0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic logic fire_of(input int g);
    int x;
    x = owner[g];
    if (x < 0) return 1'b0;
    return (TMO != 0) && m_cyc[x] && m_stb[x] && !(s_ack || s_err || s_rty) &&
           (wcnt[g] == TMO - 1);
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      owner[g] = -1;
      last[g]  = 1;
      wcnt[g]  = 0;
    end
  endtask

  // Expected outputs from the current inputs and model state.
  task automatic model_compare();
    for (int g = 0; g < 2; g++) begin
      int x;
      logic fire;
      logic [31:0] e_adr, e_dat;
      logic [3:0] e_sel;
      logic e_we, e_cyc, e_stb;
      logic [1:0] e_grant;
      logic e_ack[2];
      logic e_err[2];
      logic e_rty[2];
      x = owner[g];
      fire = fire_of(g);
      e_adr = 32'd0; e_dat = 32'd0; e_sel = 4'd0; e_we = 1'b0;
      e_cyc = 1'b0; e_stb = 1'b0; e_grant = 2'b00;
      for (int m = 0; m < 2; m++) begin
        e_ack[m] = 1'b0; e_err[m] = 1'b0; e_rty[m] = 1'b0;
      end
      if (x >= 0) begin
        e_adr = m_adr[x]; e_dat = m_wdat[x]; e_sel = m_sel[x]; e_we = m_we[x];
        e_cyc = m_cyc[x] && !fire;
        e_stb = m_stb[x] && !fire;
        e_ack[x] = s_ack;
        e_err[x] = s_err || fire;
        e_rty[x] = s_rty;
        e_grant = (x == 0) ? 2'b01 : 2'b10;
      end
      chk("s_adr", g, o_sadr[g], e_adr);
      chk("s_dat", g, o_sdat[g], e_dat);
      chk("s_sel", g, 32'(o_ssel[g]), 32'(e_sel));
      chk("s_we", g, 32'(o_swe[g]), 32'(e_we));
      chk("s_cyc", g, 32'(o_scyc[g]), 32'(e_cyc));
      chk("s_stb", g, 32'(o_sstb[g]), 32'(e_stb));
      chk("grant", g, 32'(o_grant[g]), 32'(e_grant));
      for (int m = 0; m < 2; m++) begin
        chk(m == 0 ? "m0_dat" : "m1_dat", g, o_mdat[g][m], s_rdat);
        chk(m == 0 ? "m0_ack" : "m1_ack", g, 32'(o_ack[g][m]), 32'(e_ack[m]));
        chk(m == 0 ? "m0_err" : "m1_err", g, 32'(o_err[g][m]), 32'(e_err[m]));
        chk(m == 0 ? "m0_rty" : "m1_rty", g, 32'(o_rty[g][m]), 32'(e_rty[m]));
      end
    end
  endtask

  // Advance the model across a clock edge.
  task automatic model_update();
    for (int g = 0; g < 2; g++) begin
      int x;
      logic fire;
      x = owner[g];
      fire = fire_of(g);
      if (x < 0) begin
        wcnt[g] = 0;
        if (m_cyc[0] && m_cyc[1]) owner[g] = (g == 1 || last[g] == 1) ? 0 : 1;
        else if (m_cyc[0]) owner[g] = 0;
        else if (m_cyc[1]) owner[g] = 1;
      end else begin
        if (m_cyc[x] && m_stb[x] && !(s_ack || s_err || s_rty) && !fire)
          wcnt[g] = (wcnt[g] < 65535) ? wcnt[g] + 1 : wcnt[g];
        else
          wcnt[g] = 0;
        if (!m_cyc[x]) begin
          last[g] = x;
          owner[g] = m_cyc[1 - x] ? 1 - x : -1;
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_compare();
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      m_adr[m] = 32'd0; m_wdat[m] = 32'd0; m_sel[m] = 4'd0;
      m_we[m] = 1'b0; m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
    end
    s_rdat = 32'd0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic randomize_inputs(input bit quiet);
    int t;
    for (int m = 0; m < 2; m++) begin
      if (m_cyc[m]) begin
        if ($urandom_range(0, 7) == 0) m_cyc[m] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        m_cyc[m] = 1'b1;
      end
      if (!m_cyc[m]) m_stb[m] = 1'b0;
      else if (m_stb[m]) m_stb[m] = ($urandom_range(0, 7) != 0);
      else m_stb[m] = ($urandom_range(0, 1) != 0);
      m_adr[m] = $urandom;
      m_wdat[m] = $urandom;
      m_sel[m] = 4'($urandom);
      m_we[m] = 1'($urandom);
    end
    s_rdat = $urandom;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    if ($urandom_range(0, quiet ? 15 : 2) == 0) begin
      t = $urandom_range(0, 5);
      if (t < 4) s_ack = 1'b1;
      else if (t == 4) s_err = 1'b1;
      else s_rty = 1'b1;
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;

    // reset state
    settle();
    for (int g = 0; g < 2; g++) begin
      chk("rst_grant", g, 32'(o_grant[g]), 32'h0);
      chk("rst_scyc", g, 32'(o_scyc[g]), 32'h0);
    end
    advance();

    // single master read with 2 wait states
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h4000_0010; m_sel[0] = 4'hF;
    settle();
    for (int g = 0; g < 2; g++) chk("t1_scyc_lat", g, 32'(o_scyc[g]), 32'h0);
    advance();
    settle();
    for (int g = 0; g < 2; g++) begin
      chk("t1_scyc", g, 32'(o_scyc[g]), 32'h1);
      chk("t1_sadr", g, o_sadr[g], 32'h4000_0010);
    end
    advance();
    cycle();
    s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
    settle();
    for (int g = 0; g < 2; g++) begin
      chk("t1_ack", g, 32'(o_ack[g][0]), 32'h1);
      chk("t1_dat", g, o_mdat[g][0], 32'hDEAD_BEEF);
      chk("t1_m1ack", g, 32'(o_ack[g][1]), 32'h0);
    end
    advance();
    clear_inputs();
    cycle();
    cycle();

    // tie arbitration three times
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      cycle();
      s_ack = 1'b1;
      settle();
      chk("t2_tie_rr", 0, 32'(o_grant[0]), (k == 1) ? 32'h2 : 32'h1);
      chk("t2_tie_fp", 1, 32'(o_grant[1]), 32'h1);
      advance();
      clear_inputs();
      cycle();
      cycle();
    end

    // burst hold then direct handover
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    cycle();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      for (int g = 0; g < 2; g++) begin
        chk("t3_hold", g, 32'(o_grant[g]), 32'h2);
        chk("t3_m1ack", g, 32'(o_ack[g][1]), 32'h1);
      end
      advance();
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
    cycle();
    settle();
    for (int g = 0; g < 2; g++) chk("t3_handover", g, 32'(o_grant[g]), 32'h1);
    advance();
    clear_inputs();
    cycle();

    // watchdog fires on the 8th unacknowledged strobe cycle
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    cycle();
    for (int i = 1; i <= 9; i++) begin
      settle();
      for (int g = 0; g < 2; g++) begin
        chk("t4_err", g, 32'(o_err[g][0]), (i == 8) ? 32'h1 : 32'h0);
        chk("t4_sstb", g, 32'(o_sstb[g]), (i == 8) ? 32'h0 : 32'h1);
      end
      advance();
    end
    clear_inputs();
    cycle();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    cycle();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) s_ack = 1'b1;
      settle();
      if (i == 8) begin
        for (int g = 0; g < 2; g++) begin
          chk("t4_late_ack", g, 32'(o_ack[g][0]), 32'h1);
          chk("t4_no_err", g, 32'(o_err[g][0]), 32'h0);
        end
      end
      advance();
    end
    clear_inputs();
    cycle();

    // asynchronous reset between edges during a GNT1 transfer
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    cycle();
    cycle();
    s_ack = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("t5_grant", g, 32'(o_grant[g]), 32'h0);
      chk("t5_scyc", g, 32'(o_scyc[g]), 32'h0);
      chk("t5_m1ack", g, 32'(o_ack[g][1]), 32'h0);
    end
    advance();
    rst = 1'b0;
    clear_inputs();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    cycle();
    settle();
    for (int g = 0; g < 2; g++) chk("t5_first", g, 32'(o_grant[g]), 32'h1);
    advance();
    clear_inputs();
    cycle();
    cycle();

    // err then rty passed to m1
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    cycle();
    s_err = 1'b1;
    settle();
    for (int g = 0; g < 2; g++) begin
      chk("t6_m1err", g, 32'(o_err[g][1]), 32'h1);
      chk("t6_m0err", g, 32'(o_err[g][0]), 32'h0);
    end
    advance();
    s_err = 1'b0; s_rty = 1'b1;
    settle();
    for (int g = 0; g < 2; g++) begin
      chk("t6_m1rty", g, 32'(o_rty[g][1]), 32'h1);
      chk("t6_m1err_off", g, 32'(o_err[g][1]), 32'h0);
      chk("t6_m0rty", g, 32'(o_rty[g][0]), 32'h0);
    end
    advance();
    s_rty = 1'b0;
    settle();
    for (int g = 0; g < 2; g++) chk("t6_rty_off", g, 32'(o_rty[g][1]), 32'h0);
    advance();
    clear_inputs();
    cycle();

    // randomized traffic, alternating busy and sluggish slave phases
    for (int n = 0; n < 4000; n++) begin
      randomize_inputs(((n / 200) % 2) == 1);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
